line_buffer_window: RTL

- Parametrised successor to the single-row line buffer.
- Holds KERNEL_SIZE-1 previous image rows and emits, per accepted pixel, one vertical column of KERNEL_SIZE multi-channel pixels for the downstream window/conv engine.
- Adds:
  - runtime image width and height
  - valid/ready handshakes on both sides
  - zero padding at the top of the frame
  - a window-valid flag
  - a frame state machine

---
 rtl/line_buffer_window.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/line_buffer_window.sv
// Multi-row line buffer: stores KERNEL_SIZE-1 rows and emits one
// zero-padded vertical pixel column per accepted input pixel.
module line_buffer_window #(
  parameter int DATA_WIDTH     = 8,
  parameter int CHANNELS       = 1,
  parameter int MAX_IMG_WIDTH  = 224,
  parameter int MAX_IMG_HEIGHT = 224,
  parameter int KERNEL_SIZE    = 3,
  localparam int PW = CHANNELS * DATA_WIDTH,
  localparam int CW = KERNEL_SIZE * PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [10:0]   cfg_width,
  input  logic [10:0]   cfg_height,
  output logic          busy,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [PW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_col,
  output logic          m_win_valid,
  output logic [10:0]   m_col_idx,
  output logic [10:0]   m_row_idx,
  output logic          frame_done
);

  localparam int AW = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;
  localparam logic [10:0] MAXW = 11'(MAX_IMG_WIDTH);
  localparam logic [10:0] MAXH = 11'(MAX_IMG_HEIGHT);
  localparam logic [10:0] KM1  = 11'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [10:0]   w_lat, h_lat;
  logic [10:0]   col_cnt, row_cnt;
  logic [10:0]   w_clamp, h_clamp;
  logic          accept;
  logic          col_last;
  logic          last_pix;
  logic [AW-1:0] addr;
  logic [CW-1:0] col_nxt;
  logic [PW-1:0] tap [KERNEL_SIZE];

  assign w_clamp = (cfg_width == 11'd0 || cfg_width > MAXW)
                 ? MAXW : cfg_width;
  assign h_clamp = (cfg_height == 11'd0 || cfg_height > MAXH)
                 ? MAXH : cfg_height;

  assign busy     = (state != IDLE);
  assign s_ready  = (state == RUN) && (!m_valid || m_ready);
  assign accept   = s_valid && s_ready;
  assign col_last = (col_cnt == w_lat - 11'd1);
  assign last_pix = col_last && (row_cnt == h_lat - 11'd1);
  assign addr     = col_cnt[AW-1:0];

  // tap[k] is the pixel k rows above the incoming one at this column
  assign tap[0] = s_data;

  for (genvar g = 0; g < KERNEL_SIZE - 1; g++) begin : g_row
    logic [PW-1:0] mem [MAX_IMG_WIDTH];

    assign tap[g+1] = mem[addr];

    always_ff @(posedge clk) begin
      if (accept) mem[addr] <= tap[g];
    end
  end

  always_comb begin
    col_nxt = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      if (row_cnt >= 11'(k)) col_nxt[k*PW +: PW] = tap[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (accept && last_pix) state_nxt = DONE;
      DONE: if (m_valid && m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_lat   <= '0;
      h_lat   <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (state == IDLE && start) begin
      w_lat   <= w_clamp;
      h_lat   <= h_clamp;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 11'd1;
      end else begin
        col_cnt <= col_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_col       <= '0;
      m_win_valid <= 1'b0;
      m_col_idx   <= '0;
      m_row_idx   <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= (state == DONE) && m_valid && m_ready;
      if (accept) begin
        m_valid     <= 1'b1;
        m_col       <= col_nxt;
        m_col_idx   <= col_cnt;
        m_row_idx   <= row_cnt;
        m_win_valid <= (row_cnt >= KM1) && (col_cnt >= KM1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
